pass_sender: RTL



---
 rtl/pass_sender_if.sv | 28 ++
 rtl/pass_sender.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pass_sender_if.sv
// pass_sender_if: host-side FIFO signals plus the confirm/pass_data lock link.
// master = host/lock side, slave = pass_sender.
interface pass_sender_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  logic [3:0]    push_data;
  logic          full;
  logic [CW-1:0] count;
  logic          ovf;
  logic          confirm;
  logic [3:0]    pass_data;
  logic          busy;
  logic          done;
  logic [7:0]    frames;

  modport master (
    output push, push_data,
    input  full, count, ovf, confirm, pass_data, busy, done, frames
  );

  modport slave (
    input  push, push_data,
    output full, count, ovf, confirm, pass_data, busy, done, frames
  );
endinterface

// File: rtl/pass_sender.sv
// pass_sender: transmit side of the nibble-wide confirm/pass_data lock link.
// Host pushes payload nibbles into a FIFO (push/push_data, full/count/ovf);
// each one goes out as key0..key3 + payload strobes on confirm/pass_data,
// with busy/done/frames reporting progress. clk/rst are plain ports.
// Option PASS_SENDER_RUNTIME_KEY_EN: key taken from key_in, latched per frame.
module pass_sender #(
  parameter logic [15:0] PASSWORD = 16'h8324,
  parameter int          DEPTH    = 4,
  parameter int          GAP      = 1
) (
  input  logic clk,
  input  logic rst,
`ifdef PASS_SENDER_RUNTIME_KEY_EN
  input  logic [15:0] key_in,
`endif
  pass_sender_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] GAP_M1 = 4'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_KEY, S_DATA, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    kidx_q, kidx_d;
  logic [3:0]    gcnt_q, gcnt_d;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, ovf_q, busy_q, done_q;
  logic          conf_q, conf_d;
  logic [3:0]    pd_q, pd_d;
  logic [7:0]    frames_q;
  logic          pop, push_ok;
  logic [1:0]    nidx;
  logic [3:0]    key0;
  logic [15:0]   key_f;

`ifdef PASS_SENDER_RUNTIME_KEY_EN
  logic [15:0] key_q;

  // key0 goes out straight from key_in; the rest of the frame
  // uses the copy latched on that same edge.
  assign key0  = key_in[3:0];
  assign key_f = key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0;
    end else if (state_q == S_IDLE && cnt_q != '0) begin
      key_q <= key_in;
    end
  end
`else
  assign key0  = PASSWORD[3:0];
  assign key_f = PASSWORD;
`endif

  assign nidx    = kidx_q[1:0] + 2'd1;
  assign push_ok = bus.push & (~full_q | pop);
  assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);

  // kidx: 0..3 = last strobe was key k, 4 = last strobe was payload
  always_comb begin
    state_d = state_q;
    kidx_d  = kidx_q;
    gcnt_d  = gcnt_q;
    conf_d  = 1'b0;
    pd_d    = 4'h0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          state_d = S_KEY;
          kidx_d  = 3'd0;
          conf_d  = 1'b1;
          pd_d    = key0;
        end
      end
      S_KEY, S_DATA: begin
        state_d = S_GAP;
        gcnt_d  = GAP_M1;
      end
      S_GAP: begin
        if (gcnt_q != 4'd0) begin
          gcnt_d = gcnt_q - 4'd1;
        end else if (kidx_q == 3'd4) begin
          state_d = S_IDLE;
        end else if (kidx_q == 3'd3) begin
          state_d = S_DATA;
          kidx_d  = 3'd4;
          conf_d  = 1'b1;
          pd_d    = mem[rp_q];
          pop     = 1'b1;
        end else begin
          state_d = S_KEY;
          kidx_d  = kidx_q + 3'd1;
          conf_d  = 1'b1;
          pd_d    = key_f[{nidx, 2'b00} +: 4];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp_q] <= bus.push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      kidx_q   <= '0;
      gcnt_q   <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      conf_q   <= 1'b0;
      pd_q     <= 4'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      frames_q <= 8'd0;
    end else begin
      state_q <= state_d;
      kidx_q  <= kidx_d;
      gcnt_q  <= gcnt_d;
      if (push_ok) begin
        wp_q <= wp_q + AW'(1);
      end
      if (pop) begin
        rp_q <= rp_q + AW'(1);
      end
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CW'(DEPTH));
      ovf_q  <= bus.push & ~push_ok;
      conf_q <= conf_d;
      pd_q   <= pd_d;
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_q == S_DATA);
      if (state_q == S_DATA) begin
        frames_q <= frames_q + 8'd1;
      end
    end
  end

  assign bus.full      = full_q;
  assign bus.count     = cnt_q;
  assign bus.ovf       = ovf_q;
  assign bus.confirm   = conf_q;
  assign bus.pass_data = pd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.frames    = frames_q;
endmodule
